mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder_lane_steer.sv | 49 ++++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared FSM state, access-size encodings and default latency
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int LATENCY_DEFAULT = 2;

endpackage

// File: rtl/mem_responder_lane_steer.sv
// rtl/mem_responder_lane_steer.sv - byte enables, write lane replication and read extraction
module mem_responder_lane_steer
   import mem_responder_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wlane_o,
   output logic [31:0] rext_o
);

   logic [31:0] byte_shift;
   logic [31:0] half_shift;

   assign byte_shift = rword_i >> {lane_i, 3'b000};
   assign half_shift = rword_i >> {lane_i[1], 4'b0000};

   // Right-justified write data is replicated so any enabled lane sees the right bits.
   always_comb begin
      be_o    = 4'b0000;
      wlane_o = wdata_i;
      rext_o  = 32'd0;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << lane_i;
            wlane_o = {4{wdata_i[7:0]}};
            rext_o  = {24'd0, byte_shift[7:0]};
         end
         SZ_HALF: begin
            be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
            wlane_o = {2{wdata_i[15:0]}};
            rext_o  = {16'd0, half_shift[15:0]};
         end
         SZ_WORD: begin
            be_o    = 4'b1111;
            wlane_o = wdata_i;
            rext_o  = rword_i;
         end
         default: begin
            be_o    = 4'b0000;
            wlane_o = wdata_i;
            rext_o  = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency single-port memory responder for CPU requests
// MEM_RESPONDER_SUBWORD_EN enables byte/halfword access; otherwise only word access is legal.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int LATENCY     = LATENCY_DEFAULT,
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        ack_q;
   logic        err_q;
   logic        busy_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic [31:0]   rext;
   logic [31:0]   rdata_d;
   logic          wait_done;
   logic          range_flt;
   logic          align_flt;
   logic          size_flt;
   logic          fault;

   assign idx       = addr_q[AW+1:2];
   assign wait_done = (cnt_q == 4'(LATENCY - 1));
   assign range_flt = |addr_q[31:AW+2];

   always_comb begin
      align_flt = 1'b0;
      case (size_q)
         SZ_HALF: align_flt = addr_q[0];
         SZ_WORD: align_flt = (addr_q[1:0] != 2'b00);
         default: align_flt = 1'b0;
      endcase
   end

`ifdef MEM_RESPONDER_SUBWORD_EN
   assign size_flt = (size_q == SZ_ILL);
`else
   assign size_flt = (size_q != SZ_WORD);
`endif

   assign fault   = range_flt | align_flt | size_flt;
   assign rdata_d = (fault || we_q) ? 32'd0 : rext;

   mem_responder_lane_steer u_lane_steer (
      .size_i  (size_q),
      .lane_i  (addr_q[1:0]),
      .wdata_i (wdata_q),
      .rword_i (mem_q[idx]),
      .be_o    (be),
      .wlane_o (wlane),
      .rext_o  (rext)
   );

   // Storage has no reset; a write commits only on the un-reset edge entering RESP.
   always_ff @(posedge clk_i) begin
      if (!reset_i && state_q == WAIT && wait_done && we_q && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  state_q <= WAIT;
                  busy_q  <= 1'b1;
                  cnt_q   <= 4'd0;
                  we_q    <= we_i;
                  size_q  <= size_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
               end
            end
            WAIT: begin
               if (wait_done) begin
                  state_q <= RESP;
                  ack_q   <= 1'b1;
                  err_q   <= fault;
                  rdata_q <= rdata_d;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= 4'd0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata_o = rdata_q;
   assign ack_o   = ack_q;
   assign err_o   = err_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (LATENCY=2, 256 words)
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = SZ_WORD;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        ack;
   logic        err;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_word10;

   mem_responder dut (
      .clk_i   (clk),
      .reset_i (reset),
      .req_i   (req),
      .we_i    (we),
      .size_i  (size),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .ack_o   (ack),
      .err_o   (err),
      .busy_o  (busy)
   );

   always #5 clk = ~clk;

   // Called #1 after an edge with the DUT idle; lat is the edge count after the accept edge (-1 on timeout).
   task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
      req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
      @(posedge clk); #1;
      req = 1'b0; we = ~w; size = ~sz; addr = ~a; wdata = ~wd;
      lat = -1; rd = 32'hxxxxxxxx; er = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = k; rd = rdata; er = err;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word_rw();
      logic [31:0] rd; logic er; int lat;
      run_txn(1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, rd, er, lat);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_latency got %0d want 2", lat); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b want 0", er); end
      vectors++; if (ack !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle_after got ack=%b busy=%b want 0 0", ack, busy); end
      run_txn(1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_latency got %0d want 2", lat); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b want 0", er); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", rd); end
      vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_hold got %h want deadbeef", rdata); end
   endtask

   task automatic test_subword();
      logic [31:0] rd; logic er; int lat;
`ifdef MEM_RESPONDER_SUBWORD_EN
      run_txn(1'b1, SZ_BYTE, 32'h11, 32'h000000AA, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL sb_err got %b want 0", er); end
      run_txn(1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'hDEADAAEF) begin miscompares++; $display("FAIL sb_word got %h want deadaaef", rd); end
      run_txn(1'b0, SZ_BYTE, 32'h11, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'h000000AA) begin miscompares++; $display("FAIL lb_11 got %h want 000000aa", rd); end
      run_txn(1'b0, SZ_HALF, 32'h12, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'h0000DEAD) begin miscompares++; $display("FAIL lh_12 got %h want 0000dead", rd); end
      run_txn(1'b1, SZ_HALF, 32'h12, 32'h00001234, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL sh_err got %b want 0", er); end
      run_txn(1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'h1234AAEF) begin miscompares++; $display("FAIL sh_word got %h want 1234aaef", rd); end
      run_txn(1'b0, SZ_BYTE, 32'h13, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'h00000012) begin miscompares++; $display("FAIL lb_13 got %h want 00000012", rd); end
      exp_word10 = 32'h1234AAEF;
`else
      run_txn(1'b1, SZ_BYTE, 32'h11, 32'h000000AA, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL sb_disabled_err got %b want 1", er); end
      run_txn(1'b0, SZ_HALF, 32'h10, 32'h0, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL lh_disabled got err=%b rd=%h want 1 0", er, rd); end
      run_txn(1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sb_disabled_word got %h want deadbeef", rd); end
      exp_word10 = 32'hDEADBEEF;
`endif
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic er; int lat;
      run_txn(1'b0, SZ_WORD, 32'h12, 32'h0, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL lw_12 got err=%b rd=%h want 1 0", er, rd); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL err_latency got %0d want 2", lat); end
      run_txn(1'b0, SZ_HALF, 32'h13, 32'h0, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL lh_13 got err=%b rd=%h want 1 0", er, rd); end
      run_txn(1'b1, SZ_WORD, 32'h12, 32'hFFFFFFFF, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL sw_12 got err=%b want 1", er); end
      run_txn(1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
      vectors++; if (rd !== exp_word10) begin miscompares++; $display("FAIL mis_unchanged got %h want %h", rd, exp_word10); end
   endtask

   task automatic test_range();
      logic [31:0] rd; logic er; int lat;
      run_txn(1'b0, SZ_WORD, 32'h400, 32'h0, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL rd_400 got err=%b rd=%h want 1 0", er, rd); end
      run_txn(1'b1, SZ_WORD, 32'h3FC, 32'hCAFEF00D, rd, er, lat);
      run_txn(1'b0, SZ_WORD, 32'h3FC, 32'h0, rd, er, lat);
      vectors++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rd_3fc got err=%b rd=%h want 0 cafef00d", er, rd); end
      run_txn(1'b1, SZ_WORD, 32'h0, 32'h11111111, rd, er, lat);
      run_txn(1'b1, SZ_WORD, 32'h400, 32'h22222222, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL wr_400 got err=%b want 1", er); end
      run_txn(1'b0, SZ_WORD, 32'h0, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'h11111111) begin miscompares++; $display("FAIL alias_0 got %h want 11111111", rd); end
      run_txn(1'b0, SZ_ILL, 32'h0, 32'h0, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL size11 got err=%b rd=%h want 1 0", er, rd); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd; logic er; int lat; int acks;
      run_txn(1'b1, SZ_WORD, 32'h20, 32'hA5A5A5A5, rd, er, lat);
      req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk); #1;
      req = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_wait got %b want 1", busy); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      vectors++; if (busy !== 1'b0 || ack !== 1'b0) begin miscompares++; $display("FAIL abort_idle got busy=%b ack=%b want 0 0", busy, ack); end
      reset = 1'b0;
      acks = 0;
      repeat (5) begin @(posedge clk); #1; if (ack) acks++; end
      vectors++; if (acks !== 0) begin miscompares++; $display("FAIL abort_no_ack got %0d want 0", acks); end
      run_txn(1'b0, SZ_WORD, 32'h20, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL abort_dropped got %h want a5a5a5a5", rd); end
      reset = 1'b1; req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h10;
      @(posedge clk); #1;
      reset = 1'b0; req = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_prio got busy=%b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int acks; int c0; int c1; int tail; int guard;
      acks = 0; c0 = -1; c1 = -1;
      req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h10;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (ack) begin
            if (acks == 0) c0 = k + 1; else if (acks == 1) c1 = k + 1;
            acks++;
         end
      end
      req = 1'b0;
      vectors++; if (acks !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", acks); end
      vectors++; if (c0 !== 3 || c1 !== 7) begin miscompares++; $display("FAIL b2b_cycles got %0d,%0d want 3,7", c0, c1); end
      tail = 0; guard = 0;
      while (busy && guard < 20) begin
         @(posedge clk); #1;
         if (ack) tail++;
         guard++;
      end
      repeat (4) begin @(posedge clk); #1; if (ack) tail++; end
      vectors++; if (tail !== 1 || guard >= 20) begin miscompares++; $display("FAIL b2b_tail got %0d acks guard=%0d want 1", tail, guard); end
   endtask

   initial begin
      exp_word10 = 32'hDEADBEEF;
      test_reset();
      test_word_rw();
      test_subword();
      test_misaligned();
      test_range();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule
